// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one uart_tx between NUM_REQ
// byte producers, with per-requester packet locking.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to break a packet lock
// after TIMEOUT idle cycles in HOLD. Without it, HOLD waits indefinitely
// for the owner's last byte.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | line free, round-robin arbitration from rr_ptr_q
// S_ISSUE   | data_q presented to uart_tx until it reports busy
// S_WAIT_DONE | byte on the line, waiting for tx_busy_i to fall
// S_HOLD    | packet lock held, only the owner may send the next byte

module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_data_valid_o,
  input  logic                   tx_busy_i,
  output logic [GRANT_W-1:0]     grant_o,
  output logic                   locked_o
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GRANT_W != $clog2(NUM_REQ) || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arb: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic                 locked_q, locked_d;
  logic [7:0]           data_q, data_d;

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 rr_found;
  logic [GRANT_W-1:0]   rr_winner;
  logic [GRANT_W-1:0]   next_after_grant;
  logic                 owner_valid;
  logic                 accept;
  logic [GRANT_W-1:0]   acc_idx;
  logic                 timeout_hit;

  // Rotate the valids so that bit 0 corresponds to rr_ptr_q.
  assign valid_dbl = {req_valid_i, req_valid_i} >> rr_ptr_q;
  assign valid_rot = valid_dbl[NUM_REQ-1:0];

  assign next_after_grant = (grant_q == GRANT_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;

  // First valid requester at or above rr_ptr_q, wrapping.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int j = NUM_REQ-1; j >= 0; j--) begin
      if (valid_rot[j]) begin
        rr_found  = 1'b1;
        rr_winner = GRANT_W'((int'(rr_ptr_q) + j) % NUM_REQ);
      end
    end
  end

  // Valid of the current owner, used while the lock is held.
  always_comb begin
    owner_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q == GRANT_W'(k)) owner_valid = req_valid_i[k];
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT-1);

  logic [CNT_W-1:0] to_cnt_q;

  // Down-counter armed outside HOLD; counts while the owner has nothing to send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= CNT_LOAD;
    end else if (state_q != S_HOLD || owner_valid) begin
      to_cnt_q <= CNT_LOAD;
    end else if (to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_HOLD) && !owner_valid && (to_cnt_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, accept decode and uart_tx handshake.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    locked_d        = locked_q;
    data_d          = data_q;
    req_ready_o     = '0;
    tx_data_valid_o = 1'b0;
    accept          = 1'b0;
    acc_idx         = grant_q;

    case (state_q)
      S_IDLE: begin
        // rst_n gating keeps ready low while reset is held with valids present.
        if (rst_n && rr_found && !tx_busy_i) begin
          accept  = 1'b1;
          acc_idx = rr_winner;
        end
      end
      S_ISSUE: begin
        // uart_tx latched the byte in the first ISSUE cycle; busy confirms it.
        if (tx_busy_i) begin
          state_d = S_WAIT_DONE;
        end else begin
          tx_data_valid_o = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy_i) begin
          if (locked_q) begin
            state_d = S_HOLD;
          end else begin
            rr_ptr_d = next_after_grant;
            state_d  = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (owner_valid && !tx_busy_i) begin
          accept  = 1'b1;
          acc_idx = grant_q;
        end else if (timeout_hit) begin
          locked_d = 1'b0;
          rr_ptr_d = next_after_grant;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      grant_d = acc_idx;
      state_d = S_ISSUE;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (acc_idx == GRANT_W'(k)) begin
          req_ready_o[k] = 1'b1;
          data_d         = req_data_i[8*k +: 8];
          locked_d       = ~req_last_i[k];
        end
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      locked_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
      data_q   <= data_d;
    end
  end

  assign tx_data_o = data_q;
  assign grant_o   = grant_q;
  assign locked_o  = locked_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed bench for uart_tx_arb with a uart_tx stand-in,
// queue-driven requesters and a transaction-level arbitration model.
`timescale 1ns/1ps

module tb_uart_tx_arb;
  localparam int N     = 4;
  localparam int TO    = 16;
  localparam int FRAME = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid_i, req_last_i, req_ready_o;
  logic [8*N-1:0] req_data_i;
  logic [7:0]     tx_data_o;
  logic           tx_data_valid_o, tx_busy_i, locked_o;
  logic [1:0]     grant_o;

  uart_tx_arb #(.NUM_REQ(N), .GRANT_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .tx_data_o(tx_data_o), .tx_data_valid_o(tx_data_valid_o), .tx_busy_i(tx_busy_i),
    .grant_o(grant_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // ---------------- requesters: one byte queue each ----------------
  logic [8:0] rq_mem [N][32];
  int         rq_head [N];
  int         rq_tail [N];

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      logic [8:0] e;
      e = rq_mem[k][rq_head[k] % 32];
      req_valid_i[k]       = (rq_head[k] != rq_tail[k]);
      req_last_i[k]        = (rq_head[k] != rq_tail[k]) ? e[8] : 1'b0;
      req_data_i[8*k +: 8] = (rq_head[k] != rq_tail[k]) ? e[7:0] : 8'h00;
    end
  endtask

  task automatic push_req(input int k, input logic [7:0] d, input logic last);
    rq_mem[k][rq_tail[k] % 32] = {last, d};
    rq_tail[k]++;
    drive_reqs();
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      rq_head[k] = 0;
      rq_tail[k] = 0;
    end
    drive_reqs();
  endtask

  function automatic bit reqs_empty();
    for (int k = 0; k < N; k++) if (rq_head[k] != rq_tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Pops a requester's byte after the edge on which it was accepted.
  initial begin
    logic [N-1:0] snap;
    forever begin
      @(negedge clk);
      snap = req_ready_o & req_valid_i;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (snap[k]) rq_head[k]++;
      drive_reqs();
    end
  end

  // ---------------- uart_tx stand-in and line scoreboard ----------------
  logic [7:0] exp_q[$];
  int         line_log[$];
  int         busy_left;

  initial begin
    bit lat;
    tx_busy_i = 1'b0;
    busy_left = 0;
    forever begin
      @(negedge clk);
      lat = 1'b0;
      if (!tx_busy_i && tx_data_valid_o) begin
        lat = 1'b1;
        line_log.push_back(int'(tx_data_o));
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL line_byte: got %0h on the line, expected no byte pending", tx_data_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data_o !== e) begin
            fails++;
            $display("FAIL line_byte: got %0h, expected %0h", tx_data_o, e);
          end
        end
      end
      @(posedge clk);
      #1;
      if (lat) begin
        tx_busy_i = 1'b1;
        busy_left = FRAME - 1;
      end else if (tx_busy_i) begin
        if (busy_left == 0) tx_busy_i = 1'b0;
        else busy_left--;
      end
    end
  end

  // ---------------- arbitration model and per-cycle compare ----------------
  int         m_rr, m_owner, m_grant, m_hold_cnt;
  bit         m_inflight, m_seen_busy, m_prev_acc, m_locked;
  logic [7:0] m_data;
  int         glog[$];

  task automatic model_reset();
    m_rr = 0; m_owner = -1; m_grant = 0; m_hold_cnt = 0;
    m_inflight = 0; m_seen_busy = 0; m_prev_acc = 0; m_locked = 0;
    m_data = 8'h00;
  endtask

  initial begin
    logic [N-1:0]   acc, elig, expv;
    logic [8*N-1:0] dsh;
    bit             can;
    int             exp_idx, idx, k;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_tx_valid", 32'(tx_data_valid_o), 32'd0);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_locked", 32'(locked_o), 32'd0);
        model_reset();
        exp_q.delete();
      end else begin
        acc = req_ready_o & req_valid_i;
        check("ready_onehot0", 32'($onehot0(req_ready_o)), 32'd1);
        check("ready_without_valid", 32'(req_ready_o & ~req_valid_i), 32'd0);
        check("tx_valid", 32'(tx_data_valid_o), 32'(m_prev_acc));
        check("tx_data", 32'(tx_data_o), 32'(m_data));
        check("grant", 32'(grant_o), 32'(m_grant));
        check("locked", 32'(locked_o), 32'(m_locked));

        elig = (m_owner >= 0) ? (req_valid_i & (4'(1) << m_owner)) : req_valid_i;
        can  = !m_inflight && !tx_busy_i && (elig != '0);
        exp_idx = -1;
        if (can) begin
          if (m_owner >= 0) exp_idx = m_owner;
          else begin
            for (int i = 0; i < N; i++) begin
              k = (m_rr + i) % N;
              if (exp_idx < 0 && bitof(req_valid_i, k)) exp_idx = k;
            end
          end
        end
        expv = can ? (4'(1) << exp_idx) : 4'(0);
        check("accept", 32'(acc), 32'(expv));

        m_prev_acc = (acc != '0);
        if (acc != '0) begin
          idx = 0;
          for (int i = N-1; i >= 0; i--) if (bitof(acc, i)) idx = i;
          dsh = req_data_i >> (8*idx);
          m_data   = dsh[7:0];
          m_grant  = idx;
          m_locked = !bitof(req_last_i, idx);
          exp_q.push_back(m_data);
          glog.push_back(idx);
          if (bitof(req_last_i, idx)) begin
            m_owner = -1;
            m_rr    = (idx + 1) % N;
          end else begin
            m_owner = idx;
          end
          m_inflight  = 1;
          m_seen_busy = 0;
          m_hold_cnt  = 0;
        end else if (m_inflight) begin
          if (tx_busy_i) m_seen_busy = 1;
          else if (m_seen_busy) m_inflight = 0;
        end else if (m_owner >= 0) begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          if (!bitof(req_valid_i, m_owner)) begin
            m_hold_cnt++;
            if (m_hold_cnt == TO) begin
              m_locked   = 0;
              m_rr       = (m_owner + 1) % N;
              m_owner    = -1;
              m_hold_cnt = 0;
            end
          end
`endif
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset(input bit clr);
    @(posedge clk); #2;
    rst_n = 1'b0;
    if (clr) clear_reqs();
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (!(reqs_empty() && !tx_busy_i && !m_inflight && !tx_data_valid_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL %s: traffic did not drain within %0d cycles", name, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_list(input string name, input int act[$], input int exp[$]);
    check({name, "_count"}, 32'(act.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < act.size()) check(name, 32'(act[i]), 32'(exp[i]));
    end
  endtask

  // Wait on a negedge condition with a cycle budget; returns cycles waited.
  task automatic wait_cond(input string name, input int sel, input int budget, output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (sel)
        0: hit = tx_data_valid_o;
        1: hit = tx_busy_i;
        2: hit = !tx_busy_i;
        3: hit = (req_ready_o != '0);
        4: hit = !locked_o;
        default: hit = locked_o;
      endcase
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL %s: condition not reached within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int e[$];
    int n;
    clear_reqs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // single byte from req0
    @(posedge clk); #2;
    push_req(0, 8'hA5, 1'b1);
    @(negedge clk);
    check("single_ready", 32'(req_ready_o), 32'h1);
    @(negedge clk);
    check("single_tx_valid", 32'(tx_data_valid_o), 32'd1);
    check("single_tx_data", 32'(tx_data_o), 32'hA5);
    wait_drain("single_drain", 200);
    check("single_locked", 32'(locked_o), 32'd0);

    // fairness from rr_ptr = 0
    do_reset(1);
    glog.delete(); line_log.delete();
    @(posedge clk); #2;
    push_req(0, 8'h10, 1'b1); push_req(0, 8'h14, 1'b1);
    push_req(1, 8'h21, 1'b1); push_req(2, 8'h32, 1'b1); push_req(3, 8'h43, 1'b1);
    wait_drain("fair_drain", 400);
    e = {0, 1, 2, 3, 0};
    check_list("fair_order", glog, e);
    e = {'h10, 'h21, 'h32, 'h43, 'h14};
    check_list("fair_line", line_log, e);

    // packet lock from req1 with req0 and req2 waiting
    do_reset(1);
    glog.delete(); line_log.delete();
    @(posedge clk); #2;
    push_req(1, 8'hB1, 1'b0); push_req(1, 8'hB2, 1'b0); push_req(1, 8'hB3, 1'b1);
    @(negedge clk);
    check("lock_first_ready", 32'(req_ready_o), 32'h2);
    @(posedge clk); #2;
    push_req(0, 8'hC0, 1'b1); push_req(2, 8'hD2, 1'b1);
    @(negedge clk);
    check("lock_held", 32'(locked_o), 32'd1);
    wait_drain("lock_drain", 400);
    e = {1, 1, 1, 2, 0};
    check_list("lock_order", glog, e);
    e = {'hB1, 'hB2, 'hB3, 'hD2, 'hC0};
    check_list("lock_line", line_log, e);

    // reset asserted while tx_data_valid_o is high
    do_reset(1);
    glog.delete();
    @(posedge clk); #2;
    push_req(2, 8'h5A, 1'b1); push_req(3, 8'h6B, 1'b1);
    wait_cond("rst_issue_wait", 0, 20, n);
    #1 rst_n = 1'b0;
    #1;
    check("async_ready", 32'(req_ready_o), 32'd0);
    check("async_tx_valid", 32'(tx_data_valid_o), 32'd0);
    check("async_tx_data", 32'(tx_data_o), 32'd0);
    check("async_grant", 32'(grant_o), 32'd0);
    check("async_locked", 32'(locked_o), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_cond("rst_regrant_wait", 3, 40, n);
    check("rst_regrant_busy", 32'(tx_busy_i), 32'd0);
    check("rst_regrant_ready", 32'(req_ready_o), 32'h8);
    wait_drain("rst_drain", 200);

    // abandoned lock: req3 sends a non-last byte then goes quiet
    do_reset(1);
    glog.delete();
    @(posedge clk); #2;
    push_req(3, 8'h77, 1'b0);
    wait_cond("to_busy_rise", 1, 20, n);
    push_req(0, 8'h88, 1'b1);
    wait_cond("to_busy_fall", 2, 40, n);
`ifdef UART_TX_ARB_TIMEOUT_EN
    // Busy low seen in WAIT_DONE; sixteen HOLD cycles follow, lock gone on the 17th sample.
    wait_cond("to_unlock", 4, 100, n);
    check("to_unlock_cycles", 32'(n), 32'd17);
    check("to_next_ready", 32'(req_ready_o), 32'h1);
    wait_drain("to_drain", 200);
    e = {3, 0};
    check_list("to_order", glog, e);
`else
    repeat (1100) @(negedge clk);
    check("hold_grant", 32'(grant_o), 32'd3);
    check("hold_locked", 32'(locked_o), 32'd1);
    e = {3};
    check_list("hold_order", glog, e);
    do_reset(0);
    wait_drain("hold_drain", 200);
    e = {3, 0};
    check_list("hold_after_reset", glog, e);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares one `uart_tx` instance among `NUM_REQ` byte producers, e.g. a debug console, a status reporter and a DMA drain. Each requester offers bytes on a valid/ready port. A requester can lock the transmitter for a multi-byte packet so that its bytes are never interleaved with other traffic. The block sits directly in front of `uart_tx`: it drives `tx_data_i`/`tx_data_valid` and observes `tx_busy`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GRANT_W`, 2: width of the grant index, equal to ceil(log2(NUM_REQ)).
- `TIMEOUT`, 1024: idle cycles before a packet lock is broken. Only used with `UART_TX_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock, shared with `uart_tx`.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in NUM_REQ: per-requester byte valid.
- `req_data_i` in 8*NUM_REQ: per-requester byte. Requester k uses bits [8k+7:8k].
- `req_last_i` in NUM_REQ: byte is the last of a packet, which releases the lock.
- `req_ready_o` out NUM_REQ: one-cycle accept pulse. At most one bit is set.
- `tx_data_o` out 8: connects to `uart_tx.tx_data_i`.
- `tx_data_valid_o` out 1: connects to `uart_tx.tx_data_valid`.
- `tx_busy_i` in 1: from `uart_tx.tx_busy`.
- `grant_o` out GRANT_W: index of the current or last owner.
- `locked_o` out 1: a packet lock is held.

## Operation
- A byte transfers on requester k when `req_valid_i[k] && req_ready_o[k]`.
- A requester holds valid and data stable until it is accepted.
- FSM states: IDLE, ISSUE, WAIT_DONE, HOLD.
- **IDLE**
  - Condition: any `req_valid_i` set and `tx_busy_i`=0.
  - Winner: the first valid index at or above `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Combinationally assert `req_ready_o[winner]` in the same cycle.
  - Register the byte into `data_q`, set `grant_o`=winner, set `locked_o`=~`req_last_i[winner]`, then go to ISSUE.
- **ISSUE**
  - Drive `tx_data_valid_o`=1 and `tx_data_o`=`data_q`.
  - When `tx_busy_i`=1, drop valid and go to WAIT_DONE.
  - `uart_tx` latches the byte in the first ISSUE cycle; busy rises one cycle later.
- **WAIT_DONE**
  - Wait for `tx_busy_i`=0 (stop bit finished).
  - If `locked_o`=1, go to HOLD.
  - Otherwise set `rr_ptr`=(grant+1) mod `NUM_REQ` and go to IDLE.
- **HOLD**
  - Only requester `grant_o` is eligible. Other requesters' valids are ignored.
  - When owner valid is set: accept exactly as in IDLE, update `locked_o`=~`req_last_i`, go to ISSUE.
- `tx_data_o` holds `data_q` in all states. It changes only on an accept.
- Arbitration does not reorder bytes within one requester.
- A requester that deasserts valid before being accepted loses nothing. It is not starved: after any owner finishes, `rr_ptr` always advances past that owner.
- Reset mid-transfer:
  - All state clears immediately.
  - A byte already latched by `uart_tx` finishes on the line. The arbiter waits in IDLE for `tx_busy_i`=0 before granting.
  - A locked packet is abandoned. The requester must restart it.

## Timing
- Reset values:
  - `req_ready_o`=0, `tx_data_valid_o`=0, `tx_data_o`=8'h00.
  - `grant_o`=0, `locked_o`=0.
  - `rr_ptr`=0, state=IDLE.
- Latency: accept cycle N → `tx_data_valid_o` high in cycle N+1 → `uart_tx` leaves IDLE at N+2.
- Back-to-back bytes have a minimum gap of 2 clk between `tx_busy_i` falling and the next valid: one cycle in WAIT_DONE→IDLE/HOLD, plus the accept cycle.
- The `req_ready_o` pulse lasts exactly 1 cycle per byte.
- `tx_data_valid_o` lasts 1 cycle when `uart_tx` responds normally.
- Simultaneous valids from all requesters with `rr_ptr`=0 are served in order 0,1,2,3,0…

## Configuration
- **`UART_TX_ARB_TIMEOUT_EN` defined**
  - A counter runs in HOLD while owner valid=0.
  - When it reaches `TIMEOUT`-1, the block clears `locked_o`, advances `rr_ptr` past the owner and returns to IDLE.
  - The counter clears on every accept and on leaving HOLD.
- **Not defined**
  - No counter is built.
  - HOLD waits indefinitely for the owner's last byte.

## Test plan
- Single byte: req0 sends 8'hA5 with last=1 → `req_ready_o`=4'b0001 for 1 cycle; `tx_data_o`=8'hA5 with valid the next cycle; back in IDLE after busy falls; `locked_o` stays 0.
- Fairness: all 4 requesters hold valid with last=1 → grant order 0,1,2,3,0; each `req_ready_o` bit pulses once per round.
- Packet lock: req1 sends 3 bytes (last on the third) while req0 and req2 hold valid → line carries req1's three bytes contiguously, then req2, then req0.
- Reset mid-ISSUE: assert `rst_n`=0 with `tx_data_valid_o`=1 → all outputs are at reset values asynchronously; no grant until `tx_busy_i`=0.
- Timeout (with macro, `TIMEOUT`=16): req3 sends last=0, then idles → `locked_o` clears 16 cycles into HOLD; req0 granted next.
- Timeout (without macro): same stimulus → the block stays in HOLD with `grant_o`=3 for 1000+ cycles.
